// File: rtl/scarv_cop_ctrl_pkg.sv
// Shared constants for the coprocessor instruction sequencer.
// Holds the controller state encodings, response status codes and the
// instruction-class to functional-unit index map used by fu_ivalid.
package scarv_cop_ctrl_pkg;

  localparam int NUM_CLASS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RESP   = 2'd3
  } ctrl_state_t;

  typedef enum logic [1:0] {
    RSP_OK       = 2'd0,
    RSP_ILLEGAL  = 2'd1,
    RSP_FU_ERROR = 2'd2,
    RSP_TIMEOUT  = 2'd3
  } rsp_status_t;

  // fu_ivalid bit i corresponds to decoded class value i.
  function automatic logic [NUM_CLASS-1:0] class_onehot(input logic [2:0] cls);
    class_onehot = 8'b0000_0001 << cls;
  endfunction

endpackage

// File: rtl/scarv_cop_ctrl_wdog.sv
// Execution watchdog for the coprocessor sequencer.
// Ports:
//   g_clk, g_resetn : clock, asynchronous active-low reset
//   clr             : synchronous clear of the count (takes priority over en)
//   en              : count one cycle
//   expired         : count has reached TIMEOUT-1
module scarv_cop_ctrl_wdog #(
  parameter int TIMEOUT = 256,
  parameter int TW      = 16
) (
  input  logic g_clk,
  input  logic g_resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] ONE   = TW'(1);

  logic [TW-1:0] count;

  // Cycle counter; cleared before each execution, advanced while executing.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + ONE;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/scarv_cop_ctrl.sv
// Coprocessor instruction sequencer.
// Accepts one instruction from the CPU, presents it to the decoder, dispatches
// it to the functional unit of the decoded class, waits for completion or the
// watchdog, then returns status/result to the CPU.
// Ports:
//   g_clk, g_resetn             : clock, asynchronous active-low reset
//   cpu_insn_req/ack/enc, rs1   : instruction handshake from the CPU
//   cpu_rsp_req/ack/status/...  : response handshake back to the CPU
//   id_encoded, id_exception,
//   id_class                    : registered encoding out, decode results in
//   op_rs1, fu_ivalid, fu_abort : operand, one-hot dispatch, abort pulse
//   fu_idone/error/rdata/wen    : functional unit completion and result
//   ctr_retired                 : count of responses consumed by the CPU
module scarv_cop_ctrl
  import scarv_cop_ctrl_pkg::*;
#(
  parameter logic [7:0] FU_PRESENT = 8'hFE,
  parameter int         TIMEOUT    = 256,
  parameter int         TW         = 16
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        cpu_insn_req,
  output logic        cpu_insn_ack,
  input  logic [31:0] cpu_insn_enc,
  input  logic [31:0] cpu_rs1,
  output logic        cpu_rsp_req,
  input  logic        cpu_rsp_ack,
  output logic [1:0]  cpu_rsp_status,
  output logic [31:0] cpu_rsp_wdata,
  output logic        cpu_rsp_wen,
  output logic [31:0] id_encoded,
  input  logic        id_exception,
  input  logic [2:0]  id_class,
  output logic [31:0] op_rs1,
  output logic [7:0]  fu_ivalid,
  output logic        fu_abort,
  input  logic [7:0]  fu_idone,
  input  logic        fu_error,
  input  logic [31:0] fu_rdata,
  input  logic        fu_wen,
  output logic [31:0] ctr_retired
);

  ctrl_state_t state;
  ctrl_state_t state_nxt;
  logic [2:0]  cls;
  logic        decode_legal;
  logic        sel_done;
  logic        wdog_clr;
  logic        wdog_en;
  logic        wdog_expired;

  assign decode_legal = !id_exception && FU_PRESENT[id_class];
  // Only the selected unit's completion is observed.
  assign sel_done     = fu_idone[cls];
  assign cpu_rsp_req  = (state == ST_RESP);

  scarv_cop_ctrl_wdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_wdog (
    .g_clk   (g_clk),
    .g_resetn(g_resetn),
    .clr     (wdog_clr),
    .en      (wdog_en),
    .expired (wdog_expired)
  );

  // State register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus the state-derived handshake/abort/watchdog controls.
  always_comb begin
    state_nxt    = state;
    cpu_insn_ack = 1'b0;
    fu_abort     = 1'b0;
    wdog_clr     = 1'b0;
    wdog_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        // Ack depends on state only; held low while reset is asserted.
        cpu_insn_ack = g_resetn;
        if (cpu_insn_req) begin
          state_nxt = ST_DECODE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DECODE: begin
        wdog_clr = 1'b1;
        if (decode_legal) begin
          state_nxt = ST_EXEC;
        end else begin
          state_nxt = ST_RESP;
        end
      end
      ST_EXEC: begin
        wdog_en = 1'b1;
        // Completion wins over an expiry in the same cycle.
        if (sel_done) begin
          state_nxt = ST_RESP;
        end else if (wdog_expired) begin
          fu_abort  = 1'b1;
          state_nxt = ST_RESP;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_RESP: begin
        if (cpu_rsp_ack) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_RESP;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath registers: instruction latch, dispatch, response and retire count.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      id_encoded     <= 32'd0;
      op_rs1         <= 32'd0;
      cls            <= 3'd0;
      fu_ivalid      <= 8'd0;
      cpu_rsp_status <= RSP_OK;
      cpu_rsp_wdata  <= 32'd0;
      cpu_rsp_wen    <= 1'b0;
      ctr_retired    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_insn_req) begin
            id_encoded <= cpu_insn_enc;
            op_rs1     <= cpu_rs1;
          end
        end
        ST_DECODE: begin
          if (decode_legal) begin
            cls       <= id_class;
            fu_ivalid <= class_onehot(id_class);
          end else begin
            cpu_rsp_status <= RSP_ILLEGAL;
            cpu_rsp_wdata  <= 32'd0;
            cpu_rsp_wen    <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (sel_done) begin
            fu_ivalid      <= 8'd0;
            cpu_rsp_wdata  <= fu_rdata;
            cpu_rsp_status <= fu_error ? RSP_FU_ERROR : RSP_OK;
            // A failed unit never writes the GPR.
            cpu_rsp_wen    <= fu_wen && !fu_error;
          end else if (wdog_expired) begin
            fu_ivalid      <= 8'd0;
            cpu_rsp_status <= RSP_TIMEOUT;
            cpu_rsp_wdata  <= 32'd0;
            cpu_rsp_wen    <= 1'b0;
          end
        end
        ST_RESP: begin
          if (cpu_rsp_ack) begin
            ctr_retired    <= ctr_retired + 32'd1;
            cpu_rsp_status <= RSP_OK;
            cpu_rsp_wdata  <= 32'd0;
            cpu_rsp_wen    <= 1'b0;
          end
        end
        default: begin
          fu_ivalid <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scarv_cop_ctrl.sv
// Self-checking bench for scarv_cop_ctrl. Each transaction is described by
// its encoding, when the unit completes and how the CPU acknowledges; the
// expected per-cycle waveform is derived from those facts.
module tb_scarv_cop_ctrl;

  localparam int         TMO = 4;
  localparam logic [7:0] FUP = 8'hFE;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        cpu_insn_req, cpu_insn_ack, cpu_rsp_req, cpu_rsp_ack, cpu_rsp_wen;
  logic [31:0] cpu_insn_enc, cpu_rs1, cpu_rsp_wdata, id_encoded, op_rs1, fu_rdata, ctr_retired;
  logic [1:0]  cpu_rsp_status;
  logic        id_exception, fu_abort, fu_error, fu_wen;
  logic [2:0]  id_class;
  logic [7:0]  fu_ivalid, fu_idone;

  // Decoder stub: class in the low bits, bit 31 flags an illegal encoding.
  assign id_class     = id_encoded[2:0];
  assign id_exception = id_encoded[31];

  scarv_cop_ctrl #(.FU_PRESENT(FUP), .TIMEOUT(TMO), .TW(16)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .cpu_insn_req(cpu_insn_req), .cpu_insn_ack(cpu_insn_ack),
    .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1),
    .cpu_rsp_req(cpu_rsp_req), .cpu_rsp_ack(cpu_rsp_ack),
    .cpu_rsp_status(cpu_rsp_status), .cpu_rsp_wdata(cpu_rsp_wdata),
    .cpu_rsp_wen(cpu_rsp_wen), .id_encoded(id_encoded),
    .id_exception(id_exception), .id_class(id_class), .op_rs1(op_rs1),
    .fu_ivalid(fu_ivalid), .fu_abort(fu_abort), .fu_idone(fu_idone),
    .fu_error(fu_error), .fu_rdata(fu_rdata), .fu_wen(fu_wen),
    .ctr_retired(ctr_retired)
  );

  always #5 g_clk = ~g_clk;

  int n_cmp = 0;
  int n_err = 0;
  logic        chk_en = 1'b0;
  logic        exp_ack, exp_rsp_req, exp_abort, exp_wen;
  logic [7:0]  exp_ivalid;
  logic [1:0]  exp_status;
  logic [31:0] exp_wdata, exp_enc, exp_rs1, exp_ctr;
  logic [31:0] m_enc = 32'd0, m_rs1 = 32'd0, m_ctr = 32'd0;
  int          seen_rsp_r;
  logic [1:0]  pin_status;
  logic [31:0] pin_wdata;
  logic        pin_wen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model expectations.
  always @(negedge g_clk) begin
    if (chk_en) begin
      chk("insn_ack", 32'(cpu_insn_ack), 32'(exp_ack));
      chk("rsp_req", 32'(cpu_rsp_req), 32'(exp_rsp_req));
      chk("fu_ivalid", 32'(fu_ivalid), 32'(exp_ivalid));
      chk("fu_abort", 32'(fu_abort), 32'(exp_abort));
      chk("id_encoded", id_encoded, exp_enc);
      chk("op_rs1", op_rs1, exp_rs1);
      chk("ctr_retired", ctr_retired, exp_ctr);
      if (exp_rsp_req) begin
        chk("rsp_status", 32'(cpu_rsp_status), 32'(exp_status));
        chk("rsp_wdata", cpu_rsp_wdata, exp_wdata);
        chk("rsp_wen", 32'(cpu_rsp_wen), 32'(exp_wen));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"}, 32'(cpu_insn_ack), 32'd0);
    chk({tag, "_rsp_req"}, 32'(cpu_rsp_req), 32'd0);
    chk({tag, "_status"}, 32'(cpu_rsp_status), 32'd0);
    chk({tag, "_wdata"}, cpu_rsp_wdata, 32'd0);
    chk({tag, "_wen"}, 32'(cpu_rsp_wen), 32'd0);
    chk({tag, "_enc"}, id_encoded, 32'd0);
    chk({tag, "_rs1"}, op_rs1, 32'd0);
    chk({tag, "_ivalid"}, 32'(fu_ivalid), 32'd0);
    chk({tag, "_abort"}, 32'(fu_abort), 32'd0);
    chk({tag, "_ctr"}, ctr_retired, 32'd0);
  endtask

  task automatic set_idle_exp();
    exp_ack = 1'b1; exp_rsp_req = 1'b0; exp_ivalid = 8'd0; exp_abort = 1'b0;
    exp_status = 2'd0; exp_wdata = 32'd0; exp_wen = 1'b0;
    exp_enc = m_enc; exp_rs1 = m_rs1; exp_ctr = m_ctr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cpu_insn_req = 1'b0; cpu_insn_enc = 32'hFFFF_FFFF; cpu_rs1 = 32'hFFFF_FFFF;
      cpu_rsp_ack = 1'b0; fu_idone = 8'd0; fu_error = 1'b0; fu_wen = 1'b0;
      set_idle_exp();
      @(posedge g_clk); #1;
    end
  endtask

  // One full transaction; r = 0 is the accept cycle.
  task automatic run_txn(input logic [31:0] enc, input logic [31:0] rs1,
                         input int done_at, input logic stray, input logic err,
                         input logic fwen, input logic [31:0] rdata,
                         input int ack_delay, input logic hold_req, input int rst_at);
    logic [2:0]  c;
    logic        legal, tmo, we;
    logic [1:0]  st;
    logic [31:0] wd;
    int          n, rsp_start, last;
    c     = enc[2:0];
    legal = !enc[31] && FUP[c];
    tmo   = !(done_at >= 0 && done_at < TMO);
    n     = !legal ? 0 : (tmo ? TMO : done_at + 1);
    rsp_start = 2 + n;
    last  = rsp_start + ack_delay;
    if (!legal)   begin st = 2'd1; wd = 32'd0; we = 1'b0; end
    else if (tmo) begin st = 2'd3; wd = 32'd0; we = 1'b0; end
    else if (err) begin st = 2'd2; wd = rdata; we = 1'b0; end
    else          begin st = 2'd0; wd = rdata; we = fwen; end
    seen_rsp_r = -1;
    for (int r = 0; r <= last; r++) begin
      if (cpu_rsp_req && seen_rsp_r < 0) seen_rsp_r = r;
      if (r == rsp_start) begin
        pin_status = cpu_rsp_status; pin_wdata = cpu_rsp_wdata; pin_wen = cpu_rsp_wen;
      end
      if (r == rst_at) begin
        g_resetn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        m_enc = 32'd0; m_rs1 = 32'd0; m_ctr = 32'd0;
        cpu_insn_req = 1'b0; cpu_rsp_ack = 1'b0; fu_idone = 8'd0;
        fu_error = 1'b0; fu_wen = 1'b0;
        set_idle_exp();
        #1 g_resetn = 1'b1;
        @(posedge g_clk); #1;
        return;
      end
      cpu_insn_req = (r == 0) ? 1'b1 : hold_req;
      cpu_insn_enc = (r == 0) ? enc : ~enc;
      cpu_rs1      = (r == 0) ? rs1 : ~rs1;
      cpu_rsp_ack  = (r == last);
      fu_idone = 8'd0; fu_error = 1'b0; fu_wen = 1'b0; fu_rdata = ~rdata;
      if (legal && r >= 2 && r < 2 + n) begin
        if (stray) begin
          fu_idone = 8'd1 << (c ^ 3'd4);
          fu_error = 1'b1; fu_wen = 1'b1;
        end
        if (r - 2 == done_at) begin
          fu_idone[c] = 1'b1; fu_error = err; fu_wen = fwen; fu_rdata = rdata;
        end
      end
      exp_ack     = (r == 0);
      exp_rsp_req = (r >= rsp_start);
      exp_ivalid  = (legal && r >= 2 && r < 2 + n) ? (8'd1 << c) : 8'd0;
      exp_abort   = legal && tmo && (r == 1 + n);
      exp_status  = st; exp_wdata = wd; exp_wen = we;
      exp_enc = m_enc; exp_rs1 = m_rs1; exp_ctr = m_ctr;
      @(posedge g_clk); #1;
      if (r == 0) begin m_enc = enc; m_rs1 = rs1; end
      if (r == last) m_ctr = m_ctr + 32'd1;
    end
  endtask

  initial begin
    g_resetn = 1'b0;
    cpu_insn_req = 1'b0; cpu_insn_enc = 32'd0; cpu_rs1 = 32'd0; cpu_rsp_ack = 1'b0;
    fu_idone = 8'd0; fu_error = 1'b0; fu_rdata = 32'd0; fu_wen = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    check_reset_outputs("reset");
    g_resetn = 1'b1;
    set_idle_exp();
    chk_en = 1'b1;
    idle(2);

    // Legal class 5, done in first EXEC cycle.
    run_txn(32'h0000_0005, 32'hA5A5_0001, 0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 0, 1'b0, -1);
    chk("pin_rsp_cycle", 32'(seen_rsp_r), 32'd3);
    chk("pin_status_ok", 32'(pin_status), 32'd0);
    chk("pin_wdata", pin_wdata, 32'h1234_5678);
    chk("pin_wen", 32'(pin_wen), 32'd1);
    idle(1);
    chk("pin_ctr1", ctr_retired, 32'd1);
    chk("pin_rs1", op_rs1, 32'hA5A5_0001);

    // Decoder exception.
    run_txn(32'h8000_0003, 32'h0000_0011, 0, 1'b0, 1'b0, 1'b1, 32'h5555_AAAA, 0, 1'b0, -1);
    chk("pin_ill_cycle", 32'(seen_rsp_r), 32'd2);
    chk("pin_ill_status", 32'(pin_status), 32'd1);
    // Class 0 has no unit.
    run_txn(32'h0000_0100, 32'h0000_0022, 0, 1'b0, 1'b0, 1'b1, 32'h5555_AAAA, 0, 1'b0, -1);
    chk("pin_cls0_status", 32'(pin_status), 32'd1);
    // Unit never finishes.
    run_txn(32'h0000_0002, 32'h0000_0033, -1, 1'b0, 1'b0, 1'b1, 32'h7777_7777, 0, 1'b0, -1);
    chk("pin_tmo_status", 32'(pin_status), 32'd3);
    chk("pin_tmo_cycle", 32'(seen_rsp_r), 32'd6);
    // Done on the exact expiry cycle.
    run_txn(32'h0000_0003, 32'h0000_0044, TMO - 1, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D, 0, 1'b0, -1);
    chk("pin_edge_status", 32'(pin_status), 32'd0);
    // Stray done from another unit, then error with wen.
    run_txn(32'h0000_0006, 32'h0000_0055, 2, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, -1);
    chk("pin_err_status", 32'(pin_status), 32'd2);
    chk("pin_err_wen", 32'(pin_wen), 32'd0);
    // Back-to-back at minimum interval.
    run_txn(32'h0000_0007, 32'h0000_0066, 0, 1'b0, 1'b0, 1'b0, 32'h0F0F_0F0F, 0, 1'b0, -1);
    run_txn(32'h0000_0001, 32'h0000_0077, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 0, 1'b0, -1);
    // Slow ack with insn_req held high.
    run_txn(32'h0000_0004, 32'h0000_0088, 1, 1'b0, 1'b0, 1'b1, 32'h1111_2222, 5, 1'b1, -1);
    idle(1);
    chk("pin_ctr9", ctr_retired, 32'd9);
    // Reset during EXEC.
    run_txn(32'h0000_0005, 32'h0000_0099, -1, 1'b0, 1'b0, 1'b0, 32'h3333_4444, 0, 1'b0, 3);
    idle(3);
    run_txn(32'h0000_0001, 32'h0000_00AA, 0, 1'b0, 1'b0, 1'b1, 32'h0000_ABCD, 0, 1'b0, -1);
    idle(1);
    chk("pin_ctr_after_rst", ctr_retired, 32'd1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
